// File: rtl/fsm_position.sv
// -----------------------------------------------------------------------------
// fsm_position
//   Cursor-position controller for the TicTacToe board. Tracks which of the
//   nine cells (row-major, 0 = top-left, 8 = bottom-right) is selected.
//   A one-hot direction pad moves the cursor one cell per press (wrapping
//   within the row/column), the random-move logic can load a cell directly,
//   and a victory flag parks the cursor at cell 0 and locks out input.
//
// Ports
//   clk           in  1  system clock, rising edge
//   rst           in  1  asynchronous active-high reset
//   victory       in  1  game-over flag; forces cell 0 and LOCK
//   random_found  in  1  strobe: load random_cell (if it is a legal cell)
//   direccion     in  4  one-hot pad: 0001 right, 0010 left, 0100 down, 1000 up
//   random_cell   in  4  cell index to load on random_found
//   quadrant      out 4  registered selected cell index 0..8
// -----------------------------------------------------------------------------
module fsm_position (
    input  logic       clk,
    input  logic       rst,
    input  logic       victory,
    input  logic       random_found,
    input  logic [3:0] direccion,
    input  logic [3:0] random_cell,
    output logic [3:0] quadrant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_quadrant;
    logic [3:0] w_quadrant_next;
    logic       w_dir_onehot;
    logic       w_dir_any;
    logic       w_cell_legal;

    // Apply one move to a legal cell index. Row and column are recovered with
    // comparisons instead of a divider; moves wrap inside the row or column.
    function automatic logic [3:0] move_cell(input logic [3:0] q,
                                             input logic [3:0] dir);
        logic [1:0] row;
        logic [1:0] col;
        logic [1:0] nrow;
        logic [1:0] ncol;
        logic [3:0] base;
        if (q >= 4'd6)      row = 2'd2;
        else if (q >= 4'd3) row = 2'd1;
        else                row = 2'd0;
        base = {2'b00, row} + {1'b0, row, 1'b0};   // 3 * row
        col  = 2'(q - base);
        nrow = row;
        ncol = col;
        case (dir)
            4'b0001: ncol = (col == 2'd2) ? 2'd0 : col + 2'd1;
            4'b0010: ncol = (col == 2'd0) ? 2'd2 : col - 2'd1;
            4'b0100: nrow = (row == 2'd2) ? 2'd0 : row + 2'd1;
            4'b1000: nrow = (row == 2'd0) ? 2'd2 : row - 2'd1;
            default: ;
        endcase
        return {2'b00, nrow} + {1'b0, nrow, 1'b0} + {2'b00, ncol};
    endfunction

    assign w_dir_any    = (direccion != 4'd0);
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
    assign w_dir_onehot = w_dir_any && ((direccion & (direccion - 4'd1)) == 4'd0);
    assign w_cell_legal = (random_cell <= 4'd8);

    // State register (also holds the cursor)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_quadrant <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_quadrant <= w_quadrant_next;
        end
    end

    // Next-state logic: victory > random load > direction pad
    always_comb begin
        w_state_next = r_state;
        if (victory) begin
            w_state_next = LOCK;
        end else begin
            case (r_state)
                LOCK: w_state_next = IDLE;
                IDLE: begin
                    if (random_found)
                        w_state_next = w_dir_any ? HOLD : IDLE;
                    else if (w_dir_onehot)
                        w_state_next = HOLD;
                    else
                        w_state_next = IDLE;
                end
                HOLD: w_state_next = w_dir_any ? HOLD : IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Output logic: next cursor value. A random load never also moves.
    always_comb begin
        w_quadrant_next = r_quadrant;
        if (victory) begin
            w_quadrant_next = 4'd0;
        end else if (r_state == LOCK) begin
            w_quadrant_next = r_quadrant;
        end else if (random_found) begin
            if (w_cell_legal)
                w_quadrant_next = random_cell;
        end else if ((r_state == IDLE) && w_dir_onehot) begin
            w_quadrant_next = move_cell(r_quadrant, direccion);
        end
    end

    assign quadrant = r_quadrant;

endmodule

// File: tb/tb_fsm_position.sv
module tb_fsm_position;

    logic       clk;
    logic       rst;
    logic       victory;
    logic       random_found;
    logic [3:0] direccion;
    logic [3:0] random_cell;
    logic [3:0] quadrant;

    int n_checks;
    int n_errors;

    // Reference model state: 0 idle, 1 hold, 2 lock
    int m_state;
    int m_q;

    logic [3:0] exp_q[$];

    fsm_position dut (
        .clk          (clk),
        .rst          (rst),
        .victory      (victory),
        .random_found (random_found),
        .direccion    (direccion),
        .random_cell  (random_cell),
        .quadrant     (quadrant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit is_onehot(input logic [3:0] d);
        return (d == 4'd1) || (d == 4'd2) || (d == 4'd4) || (d == 4'd8);
    endfunction

    // Behavioural model of one rising edge
    task automatic model_edge();
        int r;
        int c;
        if (rst) begin
            m_state = 0;
            m_q     = 0;
        end else if (victory) begin
            m_q     = 0;
            m_state = 2;
        end else if (m_state == 2) begin
            m_state = 0;
        end else if (random_found) begin
            if (random_cell <= 4'd8) m_q = int'(random_cell);
            m_state = (direccion != 4'd0) ? 1 : 0;
        end else if (m_state == 0) begin
            if (is_onehot(direccion)) begin
                r = m_q / 3;
                c = m_q % 3;
                case (direccion)
                    4'b0001: c = (c + 1) % 3;
                    4'b0010: c = (c + 2) % 3;
                    4'b0100: r = (r + 1) % 3;
                    default: r = (r + 2) % 3;
                endcase
                m_q     = r * 3 + c;
                m_state = 1;
            end
        end else begin
            if (direccion == 4'd0) m_state = 0;
        end
    endtask

    // Drive one cycle of stimulus, push the model's expectation, compare after the edge
    task automatic step(input logic [3:0] dir, input logic rf, input logic [3:0] rc,
                        input logic vic, input string tag);
        @(negedge clk);
        direccion    = dir;
        random_found = rf;
        random_cell  = rc;
        victory      = vic;
        model_edge();
        exp_q.push_back(4'(m_q));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            check_eq(tag, quadrant, exp_q.pop_front());
        end
    endtask

    task automatic press(input logic [3:0] dir, input string tag);
        step(dir, 1'b0, 4'd0, 1'b0, tag);
    endtask

    initial begin
        logic [3:0] dirs[6];
        n_checks     = 0;
        n_errors     = 0;
        m_state      = 0;
        m_q          = 0;
        rst          = 1'b1;
        victory      = 1'b0;
        random_found = 1'b0;
        direccion    = 4'd0;
        random_cell  = 4'd0;
        #2;
        check_eq("reset_async", quadrant, 4'd0);
        @(posedge clk);
        #1;
        check_eq("reset_hold", quadrant, 4'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) press(4'd0, "idle_zero");
        check_eq("idle_zero_const", quadrant, 4'd0);

        for (int i = 0; i < 5; i++) begin
            press(4'b0001, "hold_right");
            check_eq("hold_right_const", quadrant, 4'd1);
        end
        press(4'd0, "release");
        press(4'd0, "release");
        press(4'b0001, "right_again");
        check_eq("right_to_2", quadrant, 4'd2);

        press(4'd0, "release");
        press(4'b0001, "wrap_right");
        check_eq("wrap_right_2_0", quadrant, 4'd0);
        press(4'd0, "release");
        press(4'b1000, "wrap_up");
        check_eq("wrap_up_0_6", quadrant, 4'd6);
        press(4'd0, "release");
        press(4'b0100, "wrap_down");
        check_eq("wrap_down_6_0", quadrant, 4'd0);
        press(4'd0, "release");
        press(4'b0100, "down_0_3");
        check_eq("down_0_3", quadrant, 4'd3);
        press(4'd0, "release");
        press(4'b0010, "wrap_left");
        check_eq("wrap_left_3_5", quadrant, 4'd5);

        // Random load while down is held: no extra move
        press(4'd0, "release");
        step(4'b0100, 1'b1, 4'd7, 1'b0, "rand_load");
        check_eq("rand_load_7", quadrant, 4'd7);
        press(4'b0100, "rand_held");
        check_eq("rand_held_7", quadrant, 4'd7);
        press(4'd0, "release");
        press(4'b0100, "down_7_1");
        check_eq("down_7_1", quadrant, 4'd1);

        press(4'd0, "release");
        step(4'd0, 1'b1, 4'd12, 1'b0, "rand_illegal");
        check_eq("rand_illegal_keep", quadrant, 4'd1);
        press(4'b0011, "two_hot");
        check_eq("two_hot_nomove", quadrant, 4'd1);

        // Victory lock
        press(4'd0, "release");
        step(4'd0, 1'b1, 4'd5, 1'b0, "rand_5");
        check_eq("rand_5", quadrant, 4'd5);
        step(4'b0001, 1'b0, 4'd0, 1'b1, "victory");
        check_eq("victory_zero", quadrant, 4'd0);
        step(4'd0, 1'b0, 4'd0, 1'b1, "lock_rel");
        step(4'b0001, 1'b1, 4'd4, 1'b1, "lock_ignore");
        check_eq("lock_ignore_const", quadrant, 4'd0);
        press(4'd0, "unlock");
        press(4'b0001, "after_lock");
        check_eq("after_lock_right", quadrant, 4'd1);

        // Async reset mid-HOLD, direction still held at deassert
        press(4'b0001, "hold_before_rst");
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_hold", quadrant, 4'd0);
        m_state = 0;
        m_q     = 0;
        @(negedge clk);
        rst = 1'b0;
        press(4'b0001, "press_after_rst");
        check_eq("press_after_rst_1", quadrant, 4'd1);

        // Mixed random traffic
        dirs[0] = 4'd0; dirs[1] = 4'b0001; dirs[2] = 4'b0010;
        dirs[3] = 4'b0100; dirs[4] = 4'b1000; dirs[5] = 4'b0110;
        for (int i = 0; i < 300; i++) begin
            step(dirs[$urandom_range(0, 5)],
                 ($urandom_range(0, 9) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 24) == 0),
                 "random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
